// File: rtl/modmul_rr_arbiter_if.sv
// modmul_rr_arbiter_if: request/response bundle between requesters and the shared modular multiplier
interface modmul_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*30-1:0] req_a;
  logic [NUM_REQ*30-1:0] req_b;
  logic [NUM_REQ-1:0] req_ready;
  logic flush;
  logic rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic [29:0] rsp_data;
  logic busy;
  modport master (
    output req_valid, req_a, req_b, flush,
    input req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
  modport slave (
    input req_valid, req_a, req_b, flush,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/modmul_rr_arbiter.sv
// modmul_rr_arbiter: round-robin shared 30x30 modular multiplier with id-tagged responses; MODMUL_ARB_STATS_EN adds counters
module windowed_reduction60bit #(
  parameter int MODULAR_INDEX = 0
) (
  input logic clk,
  input logic [59:0] x,
  output logic [29:0] r
);
  localparam logic [29:0] Q_TAB [13] = '{
    30'd1063321601, 30'd1063452673, 30'd1064697857, 30'd1065484289, 30'd1065811969,
    30'd1068236801, 30'd1068433409, 30'd1068564481, 30'd1069219841, 30'd1070727169,
    30'd1071513601, 30'd1072496641, 30'd1073479681
  };
  localparam logic [29:0] Q = Q_TAB[MODULAR_INDEX];
  localparam logic [60:0] P60 = 61'(1) << 60;
  localparam logic [30:0] MU = 31'(P60 / 61'(Q));
  localparam logic [31:0] Q1 = 32'(Q);
  localparam logic [31:0] Q2 = Q1 << 1;
  logic [30:0] qh;
  logic [31:0] x1;
  logic [31:0] r2;
  always_ff @(posedge clk) begin
    qh <= 31'((62'(x[59:29]) * 62'(MU)) >> 31);
    x1 <= x[31:0];
    r2 <= x1 - 32'(qh) * Q1;
    r <= 30'(r2 >= Q2 ? r2 - Q2 : r2 >= Q1 ? r2 - Q1 : r2);
  end
endmodule

module modmul_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int MODULAR_INDEX = 0
) (
  input logic clk,
  input logic rst_n,
  modmul_rr_arbiter_if.slave bus
`ifdef MODMUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] stat_issued,
  output logic [31:0] stat_idle
`endif
);
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic gnt_any;
  logic acc;
  logic [59:0] prod;
  logic [29:0] red;
  logic [2:0] tv;
  logic [ID_W-1:0] tid [3];
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        gnt_any = 1'b1;
        gnt_id = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
  end
  assign acc = rst_n & ~bus.flush & gnt_any;
  assign bus.req_ready = acc ? NUM_REQ'(1) << gnt_id : '0;
  always_ff @(posedge clk) begin
    prod <= 60'(bus.req_a[int'(gnt_id)*30 +: 30]) * 60'(bus.req_b[int'(gnt_id)*30 +: 30]);
    tid <= '{gnt_id, tid[0], tid[1]};
  end
  windowed_reduction60bit #(.MODULAR_INDEX(MODULAR_INDEX)) u_red (
    .clk(clk),
    .x(prod),
    .r(red)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      tv <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
    end else begin
      ptr <= acc ? ID_W'((int'(gnt_id) + 1) % NUM_REQ) : ptr;
      tv <= bus.flush ? 3'b000 : {tv[1:0], acc};
      bus.rsp_valid <= tv[2] & ~bus.flush;
      bus.rsp_id <= (tv[2] && !bus.flush) ? tid[2] : bus.rsp_id;
    end
  end
  assign bus.rsp_data = bus.rsp_valid ? red : '0;
  assign bus.busy = |tv | bus.rsp_valid;
`ifdef MODMUL_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_idle <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        stat_issued[i*32 +: 32] <= stat_issued[i*32 +: 32] + 32'(bus.req_ready[i] && stat_issued[i*32 +: 32] != '1);
      stat_idle <= stat_idle + 32'(!bus.busy && bus.req_valid == '0 && stat_idle != '1);
    end
  end
`endif
endmodule

// File: doc/modmul_rr_arbiter.md
Name: modmul_rr_arbiter

Overview:
Shares one modular-multiply datapath among NUM_REQ requesters, such as butterfly units and twiddle generators. The datapath is a registered 30x30 multiplier followed by one windowed_reduction60bit instance for the selected modulus.
- Arbitrates requests round-robin.
- Tracks requester IDs through the fixed-latency pipeline.
- Returns each reduced product tagged with its requester ID.
Sits between the NTT butterfly control and the modular arithmetic datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, requester-ID width; must equal clog2(NUM_REQ).
MODULAR_INDEX, 0, modulus selector (0..12) passed to windowed_reduction60bit.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous reset, active-low.
req_valid  in  NUM_REQ  per-requester request strobe.
req_a  in  NUM_REQ*30  operand A, packed; slot i = bits [30i+29:30i]; must be < q.
req_b  in  NUM_REQ*30  operand B, packed like req_a; must be < q.
req_ready  out  NUM_REQ  one-hot grant; at most one bit high.
flush  in  1  drop all in-flight operations.
rsp_valid  out  1  result valid.
rsp_id  out  ID_W  requester that owns the result.
rsp_data  out  30  (a*b) mod q.
busy  out  1  any operation in flight.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, RR pointer=0, all tag-pipe valid bits=0.
  - req_ready is combinational; it is 0 while rst_n=0.
  - Datapath registers inside the reduction have no reset. Correctness relies only on tag-pipe valid bits.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit gets req_ready=1.
  - No request pending -> req_ready=0.
- Handshake:
  - A request is accepted in the cycle where req_valid[i] & req_ready[i] = 1.
  - The requester holds operands stable until accepted; dropping valid before grant is allowed.
  - One acceptance per cycle; there is no stall, so throughput is 1 op/cycle.
- Pointer update: on acceptance from index g, ptr <= (g+1) mod NUM_REQ. Otherwise ptr holds.
- Datapath:
  - Granted operands are muxed, multiplied, and registered as a 60-bit product at the acceptance edge.
  - The product feeds windowed_reduction60bit, which has 3 internal register stages.
- Latency: request accepted in cycle N -> rsp_valid=1 in cycle N+4, carrying that request's id and data.
- Tag pipe: 4-stage shift of {valid, id}, aligned with the datapath. Stage-0 valid = an acceptance occurred this cycle.
- Response: rsp_valid and rsp_id come from the last tag stage. rsp_data comes from the reduction output. There is no response backpressure; requesters must sink every response.
- rsp_data when rsp_valid=0 is don't-care (undefined). rsp_id is held at the last valid value.
- busy = OR of all tag-pipe valid bits.
- flush=1:
  - Clears all tag-pipe valid bits at the next edge.
  - Blocks acceptance in that cycle: req_ready=0.
  - Results already in the pipeline are never reported.
  - ptr unchanged.
- Reset mid-operation: identical to flush, plus ptr=0.
- Simultaneous flush and rst_n=0: reset wins.
- Wrap-around: a granted request at index NUM_REQ-1 sets ptr=0.
- Single requester continuously valid: granted every cycle, ordering preserved.

Optional Feature:
MODMUL_ARB_STATS_EN
- Defined: adds output stat_issued (NUM_REQ*32), one saturating 32-bit acceptance counter per requester. Also adds output stat_idle (32), a saturating count of cycles with busy=0 and no request valid.
  - All counters clear on reset; they are not cleared by flush.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- MODULAR_INDEX=0 (q=1063321601): requester 0 sends a=2, b=3 in cycle 5 -> cycle 9: rsp_valid=1, rsp_id=0, rsp_data=6. busy high cycles 6..9.
- a=b=1063321600 (q-1) -> rsp_data=1; a=0, b=q-1 -> rsp_data=0. Repeat for MODULAR_INDEX=12 (q=1073479681) with a=b=q-1 -> 1.
- All 4 requesters valid for 8 cycles with distinct operands:
  - grants rotate 0,1,2,3,0,1,2,3;
  - 8 responses appear back-to-back starting 4 cycles after the first grant;
  - ids match in order;
  - each data equals the software model.
- Requesters 1 and 3 valid, ptr=2 -> grant 3 first, then 1, then 3. Verify ptr wrap from 3 to 0.
- Accept ops in cycles 10, 11, 12; assert flush in cycle 13 -> no rsp_valid in cycles 14..16; busy=0 from cycle 14. A new request in cycle 14 responds in cycle 18.
- rst_n=0 for 1 cycle while 3 ops are in flight -> all outputs return to reset values and no stale rsp_valid appears. With MODMUL_ARB_STATS_EN defined, the counters read 0 after reset, and stat_issued[0] = 5 after 5 accepts from requester 0.
